// File: rtl/a2d_sched_pkg.sv
// Shared types and channel map for the A2D round-robin conversion scheduler.
package a2d_sched_pkg;

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_GAP, ST_READ, ST_CAPT} st_t;

  localparam logic [2:0] CH_LFT   = 3'd0;
  localparam logic [2:0] CH_RGHT  = 3'd4;
  localparam logic [2:0] CH_STEER = 3'd5;
  localparam logic [2:0] CH_BATT  = 3'd6;

  function automatic logic [2:0] slot_ch(input logic [1:0] slot);
    case (slot)
      2'd0:    return CH_LFT;
      2'd1:    return CH_RGHT;
      2'd2:    return CH_STEER;
      default: return CH_BATT;
    endcase
  endfunction

endpackage

// File: rtl/a2d_sched_if.sv
// Handshake between the conversion scheduler (master) and the A2D SPI master (slave).
interface a2d_sched_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] resp;

  modport master (output wrt, output cmd, input done, input resp);
  modport slave  (input wrt, input cmd, output done, output resp);
endinterface

// File: rtl/a2d_watchdog.sv
// Per-frame watchdog: counter cleared on each frame start, expire when it reaches TIMEOUT_CYC-1.
module a2d_watchdog #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= '0;
    else if (run && cnt != LAST)
      cnt <= cnt + 1'b1;
  end

  assign expire = run && (cnt == LAST);

endmodule

// File: rtl/a2d_sched.sv
// Round-robin ADC128S conversion scheduler: two SPI frames per request, results per slot.
// IDLE: wait for request | CMD: frame 1 in flight | GAP: SS_n spacing | READ: frame 2 | CAPT: vld cycle
module a2d_sched
  import a2d_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              nxt,
  input  logic              clr_err,
  a2d_sched_if.master       spi,
  output logic [11:0]       lft_ld,
  output logic [11:0]       rght_ld,
  output logic [11:0]       steer_pot,
  output logic [11:0]       batt,
  output logic              vld,
  output logic [1:0]        chan_idx,
  output logic              timeout_err,
  output logic [7:0]        ovr_cnt
);

  st_t              state, state_n;
  logic             wrt_q, wrt_n;
  logic [15:0]      cmd_q, cmd_n;
  logic [3:0][11:0] res_q, res_n;
  logic             vld_n, terr_n, pend, pend_n, expire, run;
  logic [1:0]       idx_n;
  logic [7:0]       ovr_n;

  assign run = (state == ST_CMD) || (state == ST_READ);

  a2d_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .load   (wrt_n),
    .run    (run),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wrt_q       <= 1'b0;
      cmd_q       <= '0;
      res_q       <= '0;
      vld         <= 1'b0;
      chan_idx    <= '0;
      timeout_err <= 1'b0;
      ovr_cnt     <= '0;
      pend        <= 1'b0;
    end else begin
      state       <= state_n;
      wrt_q       <= wrt_n;
      cmd_q       <= cmd_n;
      res_q       <= res_n;
      vld         <= vld_n;
      chan_idx    <= idx_n;
      timeout_err <= terr_n;
      ovr_cnt     <= ovr_n;
      pend        <= pend_n;
    end
  end

  always_comb begin
    state_n = state;
    wrt_n   = 1'b0;
    cmd_n   = cmd_q;
    res_n   = res_q;
    vld_n   = 1'b0;
    idx_n   = chan_idx;
    terr_n  = timeout_err;
    ovr_n   = ovr_cnt;
    pend_n  = pend;

    if (clr_err) begin
      terr_n = 1'b0;
      ovr_n  = '0;
    end

    // Clear beats a simultaneous drop; a timeout set (below) beats clear.
    if (state != ST_IDLE && nxt) begin
      if (!pend)
        pend_n = 1'b1;
      else if (!clr_err && ovr_cnt != 8'hFF)
        ovr_n = ovr_cnt + 8'd1;
    end

    case (state)
      ST_IDLE: begin
        if (nxt || pend) begin
          state_n = ST_CMD;
          wrt_n   = 1'b1;
          cmd_n   = {2'b00, slot_ch(chan_idx), 11'h000};
          pend_n  = pend && nxt;
        end
      end
      ST_CMD: begin
        if (spi.done) begin
          state_n = ST_GAP;
        end else if (expire) begin
          state_n = ST_IDLE;
          terr_n  = 1'b1;
          idx_n   = chan_idx + 2'd1;
        end
      end
      ST_GAP: begin
        state_n = ST_READ;
        wrt_n   = 1'b1;
      end
      ST_READ: begin
        if (spi.done) begin
          state_n         = ST_CAPT;
          res_n[chan_idx] = spi.resp[11:0];
          vld_n           = 1'b1;
        end else if (expire) begin
          state_n = ST_IDLE;
          terr_n  = 1'b1;
          idx_n   = chan_idx + 2'd1;
        end
      end
      ST_CAPT: begin
        state_n = ST_IDLE;
        idx_n   = chan_idx + 2'd1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign spi.wrt   = wrt_q;
  assign spi.cmd   = cmd_q;
  assign lft_ld    = res_q[0];
  assign rght_ld   = res_q[1];
  assign steer_pot = res_q[2];
  assign batt      = res_q[3];

endmodule

// File: tb/tb_a2d_sched.sv
// Self-checking bench for a2d_sched with an ADC128S-style responder behind the SPI handshake.
module tb_a2d_sched;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst, nxt, clr_err;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        vld, timeout_err;
  logic [1:0]  chan_idx;
  logic [7:0]  ovr_cnt;

  a2d_sched_if bus();

  a2d_sched #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .nxt(nxt), .clr_err(clr_err), .spi(bus),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
    .vld(vld), .chan_idx(chan_idx), .timeout_err(timeout_err), .ovr_cnt(ovr_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit hold = 1'b0;
  int lat = 5;
  logic [11:0] adc [8];
  int chmap [4] = '{0, 4, 5, 6};
  logic [15:0] cmd_log [$];
  int wrt_cyc [$];
  int vld_cyc [$];
  int done_cyc [$];

  typedef struct {
    logic [1:0]  slot;
    logic [11:0] val;
    logic [15:0] exp_cmd;
    logic [1:0]  exp_idx_next;
  } rot_vec_t;
  rot_vec_t rot [4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.wrt === 1'b1) begin
      cmd_log.push_back(bus.cmd);
      wrt_cyc.push_back(cyc);
    end
    if (vld === 1'b1) vld_cyc.push_back(cyc);
  end

  // ADC128S: each frame returns the conversion of the channel addressed in the previous frame.
  initial begin
    logic [2:0] ch, last_ch;
    last_ch = 3'd0;
    bus.done = 1'b0;
    bus.resp = 16'h0;
    forever begin
      @(negedge clk);
      if (bus.wrt === 1'b1 && !hold) begin
        ch = bus.cmd[13:11];
        repeat (lat) @(negedge clk);
        bus.done = 1'b1;
        bus.resp = {4'($urandom), adc[last_ch]};
        done_cyc.push_back(cyc);
        last_ch = ch;
        @(negedge clk);
        bus.done = 1'b0;
        bus.resp = 16'($urandom);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] reg_of(input int s);
    case (s)
      0:       return lft_ld;
      1:       return rght_ld;
      2:       return steer_pot;
      default: return batt;
    endcase
  endfunction

  task automatic do_reset();
    nxt = 1'b0;
    clr_err = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_nxt(output int at);
    at = cyc;
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
  endtask

  task automatic wait_vld(input string nm, input int budget, output int at);
    int n = 0;
    while (vld !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(vld), 32'd1);
    at = cyc;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1, "bench hang");
  end

  initial begin
    int t, tv, n;
    logic [11:0] exp_reg [4];
    int slot;

    rst = 1'b1; nxt = 1'b0; clr_err = 1'b0;
    foreach (adc[i]) adc[i] = 12'h0;
    adc[0] = 12'd350; adc[4] = 12'd500; adc[5] = 12'h800; adc[6] = 12'hC00;
    rot[0] = '{2'd0, 12'd350, 16'h0000, 2'd1};
    rot[1] = '{2'd1, 12'd500, 16'h2000, 2'd2};
    rot[2] = '{2'd2, 12'h800, 16'h2800, 2'd3};
    rot[3] = '{2'd3, 12'hC00, 16'h3000, 2'd0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_wrt", 32'(bus.wrt), 0);
    check("rst_cmd", 32'(bus.cmd), 0);
    check("rst_regs", 32'(lft_ld | rght_ld | steer_pot | batt), 0);
    check("rst_vld", 32'(vld), 0);
    check("rst_idx", 32'(chan_idx), 0);
    check("rst_terr", 32'(timeout_err), 0);
    check("rst_ovr", 32'(ovr_cnt), 0);

    // Rotation through all four slots.
    lat = 5;
    vld_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      cmd_log.delete();
      pulse_nxt(t);
      wait_vld($sformatf("rot%0d_vld", i), 200, tv);
      check($sformatf("rot%0d_idx", i), 32'(chan_idx), 32'(rot[i].slot));
      check($sformatf("rot%0d_reg", i), 32'(reg_of(int'(rot[i].slot))), 32'(rot[i].val));
      check($sformatf("rot%0d_nfr", i), 32'(cmd_log.size()), 2);
      check($sformatf("rot%0d_cmd", i), 32'(cmd_log[$]), 32'(rot[i].exp_cmd));
      repeat (1990) @(negedge clk);
      check($sformatf("rot%0d_idx_next", i), 32'(chan_idx), 32'(rot[i].exp_idx_next));
    end
    check("rot_nvld", 32'(vld_cyc.size()), 4);
    check("rot_lft", 32'(lft_ld), 350);
    check("rot_batt", 32'(batt), 'hC00);

    // Frame timing.
    lat = 7;
    cmd_log.delete(); wrt_cyc.delete(); done_cyc.delete();
    pulse_nxt(t);
    wait_vld("tim_vld", 200, tv);
    check("tim_wrt1", 32'(wrt_cyc[0]), 32'(t + 1));
    check("tim_wrt2", 32'(wrt_cyc[1]), 32'(done_cyc[0] + 2));
    check("tim_vld_cyc", 32'(tv), 32'(done_cyc[1] + 1));
    repeat (20) @(negedge clk);

    // Buffering: three requests inside one conversion.
    vld_cyc.delete(); wrt_cyc.delete();
    pulse_nxt(t);
    repeat (2) @(negedge clk);
    pulse_nxt(t);
    repeat (2) @(negedge clk);
    pulse_nxt(t);
    repeat (150) @(negedge clk);
    check("buf_nvld", 32'(vld_cyc.size()), 2);
    check("buf_nwrt", 32'(wrt_cyc.size()), 4);
    check("buf_b2b", 32'(wrt_cyc[2]), 32'(vld_cyc[0] + 2));
    check("buf_ovr", 32'(ovr_cnt), 1);

    // Request in the CAPT->IDLE cycle is buffered, not dropped.
    vld_cyc.delete();
    pulse_nxt(t);
    wait_vld("capt_vld", 200, tv);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    repeat (150) @(negedge clk);
    check("capt_nvld", 32'(vld_cyc.size()), 2);
    check("capt_ovr", 32'(ovr_cnt), 1);

    // Overrun increment, clear-vs-increment, saturation.
    hold = 1'b1;
    pulse_nxt(t);
    pulse_nxt(t);
    pulse_nxt(t);
    check("ovr_inc", 32'(ovr_cnt), 2);
    nxt = 1'b1; clr_err = 1'b1;
    @(negedge clk);
    nxt = 1'b0; clr_err = 1'b0;
    check("ovr_clr_wins", 32'(ovr_cnt), 0);
    nxt = 1'b1;
    repeat (320) @(negedge clk);
    nxt = 1'b0;
    check("ovr_sat", 32'(ovr_cnt), 255);
    hold = 1'b0;
    repeat (250) @(negedge clk);
    check("ovr_sat_hold", 32'(ovr_cnt), 255);
    check("ovr_terr", 32'(timeout_err), 1);
    pulse_clr();
    check("clr_ovr", 32'(ovr_cnt), 0);
    check("clr_terr", 32'(timeout_err), 0);

    // Watchdog expiry in the lft slot.
    do_reset();
    lat = 5;
    for (int i = 0; i < 4; i++) begin
      pulse_nxt(t);
      wait_vld($sformatf("wd_pre%0d", i), 200, tv);
      repeat (5) @(negedge clk);
    end
    check("wd_lft_before", 32'(lft_ld), 350);
    adc[0] = 12'h123;
    hold = 1'b1;
    vld_cyc.delete();
    pulse_nxt(t);
    repeat (63) @(negedge clk);
    check("wd_cyc63", 32'(timeout_err), 0);
    @(negedge clk);
    check("wd_cyc64", 32'(timeout_err), 1);
    check("wd_idx", 32'(chan_idx), 1);
    check("wd_lft_kept", 32'(lft_ld), 350);
    hold = 1'b0;
    repeat (5) @(negedge clk);
    check("wd_novld", 32'(vld_cyc.size()), 0);
    cmd_log.delete();
    pulse_nxt(t);
    wait_vld("wd_next_vld", 200, tv);
    check("wd_next_idx", 32'(chan_idx), 1);
    check("wd_next_rght", 32'(rght_ld), 500);
    check("wd_next_cmd", 32'(cmd_log[$]), 'h2000);
    repeat (5) @(negedge clk);

    // done exactly in the last watchdog cycle completes the frame.
    pulse_clr();
    lat = 63;
    pulse_nxt(t);
    wait_vld("wd63_vld", 300, tv);
    check("wd63_terr", 32'(timeout_err), 0);
    check("wd63_steer", 32'(steer_pot), 'h800);
    check("wd63_idx", 32'(chan_idx), 2);
    lat = 5;
    repeat (5) @(negedge clk);

    // clr_err coincident with timeout: set wins.
    hold = 1'b1;
    pulse_nxt(t);
    repeat (63) @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("clrset_terr", 32'(timeout_err), 1);
    check("clrset_batt", 32'(batt), 'hC00);
    pulse_clr();
    check("clr_alone", 32'(timeout_err), 0);
    hold = 1'b0;
    repeat (5) @(negedge clk);

    // Reset during READ of the steer slot.
    for (int i = 0; i < 2; i++) begin
      pulse_nxt(t);
      wait_vld($sformatf("rm_pre%0d", i), 200, tv);
      repeat (5) @(negedge clk);
    end
    lat = 20;
    cmd_log.delete();
    pulse_nxt(t);
    n = 0;
    while (cmd_log.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rm_in_read", 32'(cmd_log.size()), 2);
    check("rm_cmd_steer", 32'(cmd_log[$]), 'h2800);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rm_regs", 32'(lft_ld | rght_ld | steer_pot | batt), 0);
    check("rm_idx", 32'(chan_idx), 0);
    check("rm_ctl", 32'({bus.wrt, vld, timeout_err}), 0);
    check("rm_cmd", 32'(bus.cmd), 0);
    check("rm_ovr", 32'(ovr_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    lat = 5;
    cmd_log.delete();
    pulse_nxt(t);
    wait_vld("rm_after_vld", 200, tv);
    check("rm_after_cmd", 32'(cmd_log[0]), 0);
    check("rm_after_idx", 32'(chan_idx), 0);
    repeat (5) @(negedge clk);

    // Randomized conversions against a slot-level reference model.
    do_reset();
    foreach (exp_reg[i]) exp_reg[i] = 12'h0;
    slot = 0;
    for (int k = 0; k < 40; k++) begin
      foreach (adc[i]) adc[i] = 12'($urandom);
      lat = $urandom_range(1, 30);
      repeat ($urandom_range(0, 10)) @(negedge clk);
      cmd_log.delete();
      pulse_nxt(t);
      wait_vld($sformatf("rnd%0d_vld", k), 300, tv);
      exp_reg[slot] = adc[chmap[slot]];
      for (int s = 0; s < 4; s++)
        check($sformatf("rnd%0d_reg%0d", k, s), 32'(reg_of(s)), 32'(exp_reg[s]));
      check($sformatf("rnd%0d_idx", k), 32'(chan_idx), 32'(slot));
      check($sformatf("rnd%0d_cmd", k), 32'(cmd_log[$]), 32'(chmap[slot] * 2048));
      slot = (slot + 1) % 4;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
